// File: rtl/sum_normalizer36.sv
// Normalizes a 36-bit unsigned adder sum to a 24-bit hidden-bit mantissa with
// round-to-nearest-even, exponent saturation and denormal handling.
module sum_normalizer36 #(
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [35:0]      in_sum,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_overflow
);

  localparam logic [EXP_W-1:0] ExpOnes = '1;
  localparam logic [EXP_W-1:0] ExpOne  = EXP_W'(1);
  localparam logic [23:0]      MantHid = 24'h800000;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } state_e;

  state_e           r_state, w_state_d;
  logic [35:0]      r_work, w_work_d;
  logic [EXP_W-1:0] r_exp_work, w_exp_work_d;
  logic [23:0]      r_out_mant, w_out_mant_d;
  logic [EXP_W-1:0] r_out_exp, w_out_exp_d;
  logic             r_out_zero, w_out_zero_d;
  logic             r_out_ovf, w_out_ovf_d;
  logic             r_in_ready;
  logic             r_out_valid;

  // Rounding datapath, only consumed in StRound.
  logic [23:0]      w_mant_pre;
  logic             w_guard;
  logic             w_sticky;
  logic             w_inc;
  logic [24:0]      w_mant_sum;
  logic             w_carry;
  logic [23:0]      w_mant_rnd;
  logic [EXP_W-1:0] w_exp_inc;
  logic [EXP_W-1:0] w_exp_rnd;
  logic             w_norm_stop;

  always_comb begin
    w_mant_pre  = r_work[35:12];
    w_guard     = r_work[11];
    w_sticky    = |r_work[10:0];
    w_inc       = w_guard & (w_sticky | w_mant_pre[0]);
    w_mant_sum  = {1'b0, w_mant_pre} + {24'd0, w_inc};
    w_carry     = w_mant_sum[24];
    w_mant_rnd  = w_carry ? MantHid : w_mant_sum[23:0];
    // Saturating increment so an all-ones exponent never wraps to zero.
    w_exp_inc   = (r_exp_work == ExpOnes) ? ExpOnes : (r_exp_work + ExpOne);
    w_exp_rnd   = w_carry ? w_exp_inc : r_exp_work;
    w_norm_stop = r_work[35] | (r_exp_work <= ExpOne);
  end

  always_comb begin
    w_state_d    = r_state;
    w_work_d     = r_work;
    w_exp_work_d = r_exp_work;
    w_out_mant_d = r_out_mant;
    w_out_exp_d  = r_out_exp;
    w_out_zero_d = r_out_zero;
    w_out_ovf_d  = r_out_ovf;

    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_work_d     = in_sum;
          w_exp_work_d = in_exp;
          if (in_sum == 36'd0) begin
            w_state_d    = StDone;
            w_out_mant_d = 24'd0;
            w_out_exp_d  = '0;
            w_out_zero_d = 1'b1;
            w_out_ovf_d  = 1'b0;
          end else begin
            w_state_d = StNorm;
          end
        end
      end

      StNorm: begin
        if (w_norm_stop) begin
          w_state_d = StRound;
        end else begin
          w_work_d     = {r_work[34:0], 1'b0};
          w_exp_work_d = r_exp_work - ExpOne;
        end
      end

      StRound: begin
        w_state_d    = StDone;
        w_exp_work_d = w_exp_rnd;
        w_out_zero_d = 1'b0;
        if (w_exp_rnd == ExpOnes) begin
          w_out_mant_d = 24'd0;
          w_out_exp_d  = ExpOnes;
          w_out_ovf_d  = 1'b1;
        end else begin
          w_out_mant_d = w_mant_rnd;
          w_out_ovf_d  = 1'b0;
          if (!w_mant_rnd[23]) begin
            w_out_exp_d = '0;
          end else if (!w_mant_pre[23]) begin
            // Rounding promoted a denormal into the smallest normal.
            w_out_exp_d = ExpOne;
          end else begin
            w_out_exp_d = w_exp_rnd;
          end
        end
      end

      StDone: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  // Handshake flags are registered so both read 0 throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_work      <= 36'd0;
      r_exp_work  <= '0;
      r_out_mant  <= 24'd0;
      r_out_exp   <= '0;
      r_out_zero  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_work      <= w_work_d;
      r_exp_work  <= w_exp_work_d;
      r_out_mant  <= w_out_mant_d;
      r_out_exp   <= w_out_exp_d;
      r_out_zero  <= w_out_zero_d;
      r_out_ovf   <= w_out_ovf_d;
      r_in_ready  <= (w_state_d == StIdle);
      r_out_valid <= (w_state_d == StDone);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_mant     = r_out_mant;
  assign out_exp      = r_out_exp;
  assign out_zero     = r_out_zero;
  assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_sum_normalizer36.sv
// Directed bench for sum_normalizer36: latency, rounding, denormal, overflow,
// zero hold and mid-operation reset.
module tb_sum_normalizer36;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_sum;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  sum_normalizer36 #(.EXP_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_exp       (in_exp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mant     (out_mant),
    .out_exp      (out_exp),
    .out_zero     (out_zero),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Accept one sum, measure latency (cycle of acceptance = 1), hold DONE for
  // 'hold' cycles with out_ready low, then consume and check the return to IDLE.
  task automatic run(input string tag, input logic [35:0] sum, input logic [7:0] ex,
                     input int exp_lat, input logic [23:0] e_mant, input logic [7:0] e_exp,
                     input logic e_zero, input logic e_ovf, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_sum   = sum;
    in_exp   = ex;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum   = {4'($urandom), $urandom};
    in_exp   = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".mant"}, 64'(out_mant), 64'(e_mant));
    chk({tag, ".exp"}, 64'(out_exp), 64'(e_exp));
    chk({tag, ".zero"}, 64'(out_zero), 64'(e_zero));
    chk({tag, ".ovf"}, 64'(out_overflow), 64'(e_ovf));
    chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
      chk({tag, ".hold_mant"}, 64'(out_mant), 64'(e_mant));
      chk({tag, ".hold_exp"}, 64'(out_exp), 64'(e_exp));
      chk({tag, ".hold_zero"}, 64'(out_zero), 64'(e_zero));
    end
    @(negedge clk);
    out_ready = 1'b1;
    chk({tag, ".no_bypass"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 36'd0;
    in_exp    = 8'd0;
    out_ready = 1'b0;

    // Reset values with the clock running.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_mant", 64'(out_mant), 64'd0);
    chk("rst.out_exp", 64'(out_exp), 64'd0);
    chk("rst.out_zero", 64'(out_zero), 64'd0);
    chk("rst.out_ovf", 64'(out_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.ready_first_edge", 64'(in_ready), 64'd1);

    // Already normalized.
    run("norm0", 36'h800000000, 8'd100, 3, 24'h800000, 8'd100, 1'b0, 1'b0, 0);
    // Maximum shift count.
    run("shift35", 36'h000000001, 8'd127, 38, 24'h800000, 8'd92, 1'b0, 1'b0, 0);
    // Round-to-nearest-even ties and a sticky round-up.
    run("tie_even", 36'h800000800, 8'd50, 3, 24'h800000, 8'd50, 1'b0, 1'b0, 0);
    run("tie_up", 36'h800001800, 8'd50, 3, 24'h800002, 8'd50, 1'b0, 1'b0, 0);
    run("sticky_up", 36'h800000801, 8'd50, 3, 24'h800001, 8'd50, 1'b0, 1'b0, 0);
    // Carry-out into the saturating exponent.
    run("carry_ovf", 36'hFFFFFF800, 8'd254, 3, 24'h000000, 8'd255, 1'b0, 1'b1, 0);
    run("exp_ones", 36'h800000000, 8'd255, 3, 24'h000000, 8'd255, 1'b0, 1'b1, 0);
    // Normalization stopped at exponent 1 leaves a denormal.
    run("denorm_stop", 36'h080000000, 8'd3, 5, 24'h200000, 8'd0, 1'b0, 1'b0, 0);
    // Rounding lifts a denormal to bit 23.
    run("denorm_rnd", 36'h7FFFFF800, 8'd1, 3, 24'h800000, 8'd1, 1'b0, 1'b0, 0);
    // Zero exponent performs no shifts.
    run("exp_zero", 36'h000001000, 8'd0, 3, 24'h000001, 8'd0, 1'b0, 1'b0, 0);
    // Zero sum, held for 5 cycles with out_ready low.
    run("zero", 36'h000000000, 8'd77, 1, 24'h000000, 8'd0, 1'b1, 1'b0, 5);

    // Reset pulsed mid-normalization abandons the operation.
    @(negedge clk);
    in_sum   = 36'h000000010;
    in_exp   = 8'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", 64'(in_ready), 64'd0);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.out_zero", 64'(out_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.ready_after", 64'(in_ready), 64'd1);
    seen_valid = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    chk("midrst.no_output", 64'(seen_valid), 64'd0);
    run("after_rst", 36'h000000010, 8'd100, 34, 24'h800000, 8'd69, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
